// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: single-port word memory, one request in flight, valid_data pulses WAIT_CYCLES+2 edges after accept.
// req_ready low while busy (requests ignored, not queued); DATA_MEM_STATS_EN adds rd_count/wr_count.
module data_mem_ctrl #(
  parameter int MEM_DEPTH   = 64,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_CYCLES = 2,
  localparam int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  valid_data
`ifdef DATA_MEM_STATS_EN
  ,
  output logic [15:0]           rd_count,
  output logic [15:0]           wr_count
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

  localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t                r_state;
  state_t                w_next;
  logic [3:0]            r_wait_cnt;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_valid_data;
  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  logic w_ready;
  logic w_access;
  logic w_resp;
  logic w_accept;
  logic w_wait_done;

  assign w_accept    = req_valid && w_ready;
  assign w_wait_done = (r_wait_cnt == WAIT_LAST);

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
      S_WAIT:   if (w_wait_done) w_next = S_ACCESS;
      S_ACCESS: w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_ready  = 1'b0;
    w_access = 1'b0;
    w_resp   = 1'b0;
    case (r_state)
      S_IDLE:   w_ready  = 1'b1;
      S_ACCESS: w_access = 1'b1;
      S_RESP:   w_resp   = 1'b1;
      default:  ;
    endcase
  end

  // Request is latched once on accept; later input changes cannot disturb it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wait_cnt <= 4'd0;
    end else if (w_accept) begin
      r_we       <= we;
      r_addr     <= addr;
      r_wdata    <= wdata;
      r_wait_cnt <= 4'd0;
    end else if (r_state == S_WAIT) begin
      r_wait_cnt <= r_wait_cnt + 4'd1;
    end
  end

  // valid_data is registered off RESP, so the pulse lands WAIT_CYCLES+2 edges after accept.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rdata      <= '0;
      r_valid_data <= 1'b0;
    end else begin
      r_valid_data <= w_resp;
      if (w_access && !r_we) r_rdata <= r_mem[r_addr];
    end
  end

  // Array has no reset; an ACCESS edge with reset low must not commit.
  always_ff @(posedge clk) begin
    if (reset && w_access && r_we) r_mem[r_addr] <= r_wdata;
  end

`ifdef DATA_MEM_STATS_EN
  logic [15:0] r_rd_count;
  logic [15:0] r_wr_count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rd_count <= 16'd0;
      r_wr_count <= 16'd0;
    end else if (w_access) begin
      if (r_we && r_wr_count != 16'hFFFF)  r_wr_count <= r_wr_count + 16'd1;
      if (!r_we && r_rd_count != 16'hFFFF) r_rd_count <= r_rd_count + 16'd1;
    end
  end

  assign rd_count = r_rd_count;
  assign wr_count = r_wr_count;
`endif

  assign req_ready  = w_ready;
  assign rdata      = r_rdata;
  assign valid_data = r_valid_data;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: transaction-level model checked every cycle, plus directed literal checks.
// Instance 0 uses WAIT_CYCLES=2, instance 1 uses WAIT_CYCLES=0.
module tb_data_mem_ctrl;
  localparam int DW = 32;
  localparam int AW = 6;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [1:0]    req_valid;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [1:0]    req_ready;
  logic [1:0]    valid_data;
  logic [DW-1:0] rdata0, rdata1;
`ifdef DATA_MEM_STATS_EN
  logic [15:0]   rd_count0, wr_count0, rd_count1, wr_count1;
`endif

  data_mem_ctrl #(.MEM_DEPTH(DEPTH), .DATA_WIDTH(DW), .WAIT_CYCLES(2)) u_dut0 (
    .clk(clk), .reset(reset), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .we(we), .addr(addr), .wdata(wdata), .rdata(rdata0), .valid_data(valid_data[0])
`ifdef DATA_MEM_STATS_EN
    , .rd_count(rd_count0), .wr_count(wr_count0)
`endif
  );

  data_mem_ctrl #(.MEM_DEPTH(DEPTH), .DATA_WIDTH(DW), .WAIT_CYCLES(0)) u_dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .we(we), .addr(addr), .wdata(wdata), .rdata(rdata1), .valid_data(valid_data[1])
`ifdef DATA_MEM_STATS_EN
    , .rd_count(rd_count1), .wr_count(wr_count1)
`endif
  );

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int wc(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  // Transaction model: one pending request per instance, commit at accept+W+1,
  // visible completion pulse at accept+W+2, ready again from the pulse cycle on.
  logic [31:0]   m_mem [2][DEPTH];
  bit            m_pend [2];
  bit            m_we [2];
  logic [AW-1:0] m_addr [2];
  logic [31:0]   m_wdata [2];
  int            m_commit [2];
  int            m_pulse [2];
  bit            m_vld [2];
  bit            m_ready [2];
  logic [31:0]   m_rdata [2];
  int            m_rd [2];
  int            m_wr [2];
  int            edge_cnt = 0;
  bit            live = 0;

  always @(posedge clk) begin
    bit was_idle;
    edge_cnt++;
    for (int i = 0; i < 2; i++) begin
      if (!reset) begin
        m_pend[i]  = 0;
        m_vld[i]   = 0;
        m_rdata[i] = 32'h0;
        m_rd[i]    = 0;
        m_wr[i]    = 0;
      end else begin
        was_idle = !m_pend[i];
        m_vld[i] = 0;
        if (m_pend[i] && edge_cnt == m_commit[i]) begin
          if (m_we[i]) begin
            m_mem[i][m_addr[i]] = m_wdata[i];
            if (m_wr[i] < 65535) m_wr[i]++;
          end else begin
            m_rdata[i] = m_mem[i][m_addr[i]];
            if (m_rd[i] < 65535) m_rd[i]++;
          end
        end
        if (m_pend[i] && edge_cnt == m_pulse[i]) begin
          m_vld[i]  = 1;
          m_pend[i] = 0;
        end
        if (was_idle && req_valid[i]) begin
          m_pend[i]   = 1;
          m_we[i]     = we;
          m_addr[i]   = addr;
          m_wdata[i]  = wdata;
          m_commit[i] = edge_cnt + wc(i) + 1;
          m_pulse[i]  = edge_cnt + wc(i) + 2;
        end
      end
      m_ready[i] = !m_pend[i];
    end
    live = 1;
  end

  always @(negedge clk) begin
    if (live) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("i%0d_req_ready", i), {31'd0, req_ready[i]}, {31'd0, m_ready[i]});
        chk($sformatf("i%0d_valid_data", i), {31'd0, valid_data[i]}, {31'd0, m_vld[i]});
        chk($sformatf("i%0d_rdata", i), (i == 0) ? rdata0 : rdata1, m_rdata[i]);
      end
`ifdef DATA_MEM_STATS_EN
      chk("i0_rd_count", {16'd0, rd_count0}, 32'(m_rd[0]));
      chk("i0_wr_count", {16'd0, wr_count0}, 32'(m_wr[0]));
      chk("i1_rd_count", {16'd0, rd_count1}, 32'(m_rd[1]));
      chk("i1_wr_count", {16'd0, wr_count1}, 32'(m_wr[1]));
`endif
    end
  end

  // Entered and left just after a rising edge.
  task automatic do_req(input int i, input bit w, input logic [AW-1:0] a, input logic [31:0] d,
                        output int lat, output logic [31:0] rd);
    int  e_acc;
    bit  ok;
    lat = -1;
    rd  = 32'h0;
    we = w; addr = a; wdata = d; req_valid[i] = 1'b1;
    ok = 0;
    for (int c = 0; c < 40 && !ok; c++) begin
      @(negedge clk);
      if (req_ready[i]) ok = 1;
    end
    if (!ok) begin
      chk("accept_timeout", 32'd0, 32'd1);
      req_valid[i] = 1'b0;
      @(posedge clk); #1;
      return;
    end
    @(posedge clk); #1;
    e_acc = edge_cnt;
    req_valid[i] = 1'b0;
    we = ~w; addr = ~a; wdata = ~d;
    ok = 0;
    for (int c = 0; c < 40 && !ok; c++) begin
      @(negedge clk);
      if (valid_data[i]) begin
        ok  = 1;
        lat = edge_cnt - e_acc;
        rd  = (i == 0) ? rdata0 : rdata1;
      end
    end
    if (!ok) chk("valid_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          lat;
    int          np;
    logic [31:0] rd;
    int          acc_c[$];

    reset = 1'b0; req_valid = 2'b00; we = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'd0, req_ready[0]}, 32'd1);
    chk("rst_valid", {31'd0, valid_data[0]}, 32'd0);
    chk("rst_rdata", rdata0, 32'h0);
    chk("rst_ready_w0", {31'd0, req_ready[1]}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;

    do_req(0, 1'b1, 6'd5, 32'hDEADBEEF, lat, rd);
    chk("wr5_latency", 32'(lat), 32'd4);
    do_req(0, 1'b0, 6'd5, 32'h0, lat, rd);
    chk("rd5_latency", 32'(lat), 32'd4);
    chk("rd5_data", rd, 32'hDEADBEEF);

    do_req(0, 1'b1, 6'd63, 32'h12345678, lat, rd);
    do_req(0, 1'b1, 6'd0, 32'hA5A5A5A5, lat, rd);
    do_req(0, 1'b0, 6'd63, 32'h0, lat, rd);
    chk("rd63_data", rd, 32'h12345678);
    do_req(0, 1'b0, 6'd0, 32'h0, lat, rd);
    chk("rd0_data", rd, 32'hA5A5A5A5);

    // req_valid held high while addr/wdata change every cycle.
    req_valid[0] = 1'b1; we = 1'b1;
    for (int c = 0; c < 10; c++) begin
      addr = 6'(20 + c); wdata = 32'(100 + c);
      @(negedge clk);
      if (req_ready[0]) acc_c.push_back(c);
      @(posedge clk); #1;
    end
    req_valid[0] = 1'b0;
    repeat (8) @(posedge clk); #1;
    chk("held_accepts", 32'(acc_c.size()), 32'd2);
    if (acc_c.size() == 2) begin
      chk("held_first", 32'(acc_c[0]), 32'd0);
      chk("held_second", 32'(acc_c[1]), 32'd5);
    end
    do_req(0, 1'b0, 6'd20, 32'h0, lat, rd);
    chk("rd20_data", rd, 32'd100);
    do_req(0, 1'b0, 6'd25, 32'h0, lat, rd);
    chk("rd25_data", rd, 32'd105);

    // Reset while a write waits: memory keeps old data, no completion pulse.
    do_req(0, 1'b1, 6'd7, 32'h1, lat, rd);
    we = 1'b1; addr = 6'd7; wdata = 32'hFFFFFFFF; req_valid[0] = 1'b1;
    np = 0;
    for (int c = 0; c < 40 && !req_ready[0]; c++) @(negedge clk);
    @(posedge clk); #1;
    req_valid[0] = 1'b0; reset = 1'b0;
    repeat (2) begin
      @(negedge clk); if (valid_data[0]) np++;
      @(posedge clk); #1;
    end
    reset = 1'b1;
    repeat (6) begin
      @(negedge clk); if (valid_data[0]) np++;
      @(posedge clk); #1;
    end
    chk("abort_wait_pulses", 32'(np), 32'd0);
    do_req(0, 1'b0, 6'd7, 32'h0, lat, rd);
    chk("rd7_after_abort", rd, 32'h1);

    // Zero-wait instance, including reset landing on its ACCESS edge.
    do_req(1, 1'b1, 6'd3, 32'h55, lat, rd);
    chk("w0_wr_latency", 32'(lat), 32'd2);
    do_req(1, 1'b0, 6'd3, 32'h0, lat, rd);
    chk("w0_rd_latency", 32'(lat), 32'd2);
    chk("w0_rd3_data", rd, 32'h55);
    we = 1'b1; addr = 6'd3; wdata = 32'h66; req_valid[1] = 1'b1;
    np = 0;
    for (int c = 0; c < 40 && !req_ready[1]; c++) @(negedge clk);
    @(posedge clk); #1;
    req_valid[1] = 1'b0; reset = 1'b0;
    @(negedge clk); if (valid_data[1]) np++;
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (5) begin
      @(negedge clk); if (valid_data[1]) np++;
      @(posedge clk); #1;
    end
    chk("abort_access_pulses", 32'(np), 32'd0);
    do_req(1, 1'b0, 6'd3, 32'h0, lat, rd);
    chk("w0_rd3_after_abort", rd, 32'h55);

`ifdef DATA_MEM_STATS_EN
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    do_req(0, 1'b1, 6'd40, 32'h40, lat, rd);
    do_req(0, 1'b1, 6'd41, 32'h41, lat, rd);
    do_req(0, 1'b1, 6'd42, 32'h42, lat, rd);
    do_req(0, 1'b0, 6'd40, 32'h0, lat, rd);
    do_req(0, 1'b0, 6'd42, 32'h0, lat, rd);
    @(negedge clk);
    chk("stats_wr_count", {16'd0, wr_count0}, 32'd3);
    chk("stats_rd_count", {16'd0, rd_count0}, 32'd2);
    @(posedge clk); #1;
`endif

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
